chip8_sprite_drawer: RTL and testbench
======================================

# chip8_sprite_drawer

Sprite draw engine for the CHIP-8 DXYN instruction and the write-side initiator of the framebuffer's general-purpose port. On a start request it fetches N sprite bytes from main memory, starting at the I register address. It XORs each set sprite bit into the 64x32 one-bit framebuffer using read-modify-write, and reports a collision (VF) when any lit pixel is turned off. It sits between the CPU execute stage, main memory read port and framebuffer port.

## Interface
Parameters: none (framebuffer geometry fixed at 64x32, memory 4096x8).
- clk  in  1  system clock (50 MHz), sole clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  draw request; accepted only in IDLE
- x  in  6  sprite origin column (VX mod 64)
- y  in  5  sprite origin row (VY mod 32)
- n  in  4  sprite height in rows, 0..15
- i_addr  in  12  sprite base address (I register)
- busy  out  1  high from cycle after accepted start until DONE inclusive
- done  out  1  one-cycle pulse on completion
- collision  out  1  VF result; valid from done, held until next accepted start
- mem_addr  out  12  main memory read address
- mem_readdata  in  8  memory data, valid 1 cycle after mem_addr
- fb_addr_x  out  6  framebuffer column
- fb_addr_y  out  5  framebuffer row
- fb_writedata  out  1  pixel write value
- fb_WE  out  1  framebuffer write enable
- fb_readdata  in  1  framebuffer pixel, valid 1 cycle after address presented

## Operation
- States: IDLE, FETCH, LOAD, PIXEL, WRITE, DONE.
- IDLE: when start=1, latch x, y, n, i_addr. Clear collision and the row counter. Go to FETCH, or to DONE if n=0.
- FETCH: mem_addr = i_addr + row, modulo 4096 (12-bit wrap).
- LOAD: capture mem_readdata into the row shift register. Set bit counter to 0 and go to PIXEL.
- PIXEL: current bit is the MSB-first bit. Drive fb_addr_x = x + bit (6-bit wrap) and fb_addr_y = y + row (5-bit wrap), with fb_WE=0.
  - If the bit is 1, go to WRITE.
  - If the bit is 0, advance the bit.
- WRITE: drive the same address with fb_WE=1 and fb_writedata = ~fb_readdata. If fb_readdata=1, set collision. Then advance the bit.
- Bit advance:
  - After bit 7, if row = n-1, go to DONE.
  - After bit 7 otherwise, increment row and go to FETCH.
  - Otherwise stay in PIXEL with bit+1.
- DONE: done=1 for one cycle, then IDLE.
- Wrap-around: pixels past column 63 or row 31 wrap to 0 (no clipping).
- start asserted while not in IDLE is ignored. No queueing.
- fb_WE is high only in WRITE. Zero sprite bits never generate framebuffer writes.
- Outputs other than fb_writedata depend only on registered state. fb_writedata is the sole combinational path (from fb_readdata).
- When idle, fb_addr_x, fb_addr_y and mem_addr hold their last values. fb_writedata=0 outside WRITE.

## Timing
- Reset (async, immediate): state IDLE. busy=0, done=0, collision=0, fb_WE=0, fb_writedata=0, fb_addr_x=0, fb_addr_y=0, mem_addr=0.
- Reset asserted mid-draw aborts at once. Partial writes already committed remain. No done pulse.
- Start accepted at edge E0; FETCH occupies the next cycle.
- Per row: 2 cycles (FETCH, LOAD) + 8 PIXEL cycles + 1 WRITE cycle per set bit.
- Total from E0 to the done cycle: 10·n + P + 1 cycles, where P is the total set bits. The done cycle is the last one.
- n=0: done is asserted in the first cycle after E0, with collision=0.
- A new start is accepted in the cycle after done (IDLE).
- Pixels within a draw are serialized, so a second write to the same pixel in one draw sees the first write (the read-after-write gap is at least 1 cycle).

## Test plan
- Draw x=0, y=0, n=1, byte 0xF0 on a cleared buffer.
  - Required: pixels (0..3,0)=1, fb_WE pulses exactly 4 times, done at cycle 15 after accept, collision=0.
- Repeat the identical draw.
  - Required: pixels (0..3,0) return to 0, collision=1.
- Draw x=62, y=31, n=2, bytes 0xC0 and 0xC0.
  - Required: writes to (62,31), (63,31), (62,0), (63,0).
- i_addr=0xFFF, n=2.
  - Required: mem_addr sequence 0xFFF then 0x000.
- n=0.
  - Required: no fb_WE, done one cycle after accept, collision cleared from a prior 1.
- Assert reset_n=0 mid-row on a 5-row draw, then release.
  - Required: fb_WE=0 immediately, busy=0, no done. A new start is then accepted.

Source files
------------

// File: rtl/chip8_sprite_drawer_if.sv
// Bundle of signals between the sprite drawer and its environment.
// The environment side is the CPU execute stage, the main memory read port and
// the framebuffer port. The drawer side is the sprite engine itself.
interface chip8_sprite_drawer_if;
    // CPU execute stage request and result
    logic        start;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [3:0]  n;
    logic [11:0] i_addr;
    logic        busy;
    logic        done;
    logic        collision;
    // Main memory read port
    logic [11:0] mem_addr;
    logic [7:0]  mem_readdata;
    // Framebuffer general-purpose port
    logic [5:0]  fb_addr_x;
    logic [4:0]  fb_addr_y;
    logic        fb_writedata;
    logic        fb_WE;
    logic        fb_readdata;

    // Environment: issues draw requests, answers memory and framebuffer reads
    modport master (
        output start, x, y, n, i_addr,
        input  busy, done, collision,
        input  mem_addr,
        output mem_readdata,
        input  fb_addr_x, fb_addr_y, fb_writedata, fb_WE,
        output fb_readdata
    );

    // Sprite drawer: accepts requests, initiates memory reads and pixel writes
    modport slave (
        input  start, x, y, n, i_addr,
        output busy, done, collision,
        output mem_addr,
        input  mem_readdata,
        output fb_addr_x, fb_addr_y, fb_writedata, fb_WE,
        input  fb_readdata
    );
endinterface

// File: rtl/chip8_sprite_drawer.sv
// CHIP-8 DXYN sprite draw engine.
// Fetches N sprite bytes starting at I, then XORs every set bit into the 64x32
// framebuffer with a read-modify-write per pixel. Collision is raised when a
// lit pixel gets turned off. Zero bits cost one cycle and never write.
module chip8_sprite_drawer (
    input  logic                        clk,
    input  logic                        reset_n,
    chip8_sprite_drawer_if.slave        bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PIXEL = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [5:0]  x_reg;
    logic [4:0]  y_reg;
    logic [3:0]  n_reg;
    logic [3:0]  row_reg;
    logic [2:0]  bit_reg;
    logic [7:0]  shift_reg;
    logic [11:0] mem_addr_reg;
    logic [5:0]  fb_x_reg;
    logic [4:0]  fb_y_reg;
    logic        collision_reg;

    logic        advance;
    logic        last_bit;
    logic        last_row;

    // A pixel is finished either as a clear bit in PIXEL or after its WRITE
    assign advance  = ((state_reg == PIXEL) && !shift_reg[7]) || (state_reg == WRITE);
    assign last_bit = (bit_reg == 3'd7);
    // n_reg is never zero here: n=0 skips straight to DONE
    assign last_row = (row_reg == (n_reg - 4'd1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.n == 4'd0) ? DONE : FETCH;
                end
            end
            FETCH:   state_next = LOAD;
            LOAD:    state_next = PIXEL;
            PIXEL:   state_next = shift_reg[7] ? WRITE : PIXEL;
            WRITE:   state_next = PIXEL;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (advance && last_bit) begin
            state_next = last_row ? DONE : FETCH;
        end
    end

    // Outputs decoded from registered state; fb_writedata is the only
    // combinational path, inverting the pixel being read back in WRITE
    always_comb begin
        bus.busy         = (state_reg != IDLE);
        bus.done         = (state_reg == DONE);
        bus.fb_WE        = (state_reg == WRITE);
        bus.fb_writedata = (state_reg == WRITE) ? ~bus.fb_readdata : 1'b0;
        bus.collision    = collision_reg;
        bus.mem_addr     = mem_addr_reg;
        bus.fb_addr_x    = fb_x_reg;
        bus.fb_addr_y    = fb_y_reg;
    end

    // Datapath: request latch, row/bit counters, sprite byte, addresses, VF
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_reg         <= '0;
            y_reg         <= '0;
            n_reg         <= '0;
            row_reg       <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            mem_addr_reg  <= '0;
            fb_x_reg      <= '0;
            fb_y_reg      <= '0;
            collision_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        x_reg         <= bus.x;
                        y_reg         <= bus.y;
                        n_reg         <= bus.n;
                        row_reg       <= '0;
                        collision_reg <= 1'b0;
                        // An empty sprite never reads memory, so the address holds
                        if (bus.n != 4'd0) begin
                            mem_addr_reg <= bus.i_addr;
                        end
                    end
                end
                LOAD: begin
                    shift_reg <= bus.mem_readdata;
                    bit_reg   <= '0;
                    fb_x_reg  <= x_reg;
                    fb_y_reg  <= y_reg + {1'b0, row_reg};
                end
                WRITE: begin
                    if (bus.fb_readdata) begin
                        collision_reg <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (advance) begin
                if (last_bit) begin
                    if (!last_row) begin
                        row_reg      <= row_reg + 4'd1;
                        // Sprite bytes are consecutive; the 12-bit add wraps at 4096
                        mem_addr_reg <= mem_addr_reg + 12'd1;
                    end
                end else begin
                    bit_reg   <= bit_reg + 3'd1;
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    // Column wraps naturally at 64
                    fb_x_reg  <= fb_x_reg + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Directed testbench for chip8_sprite_drawer with behavioural memory and
// framebuffer models, both with one-cycle registered reads.
`timescale 1ns/1ps
module tb_chip8_sprite_drawer;

    logic clk;
    logic reset_n;

    chip8_sprite_drawer_if bus ();

    chip8_sprite_drawer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0] mem [0:4095];
    logic       fb  [0:31][0:63];

    int          checks;
    int          errors;
    int          we_count;
    int          done_count;
    int          wlog[$];
    logic [11:0] mlog[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory: registered read
    always @(posedge clk) begin
        bus.mem_readdata <= mem[bus.mem_addr];
    end

    // Framebuffer: registered read, synchronous write
    always @(posedge clk) begin
        if (bus.fb_WE) begin
            fb[bus.fb_addr_y][bus.fb_addr_x] <= bus.fb_writedata;
        end
        bus.fb_readdata <= fb[bus.fb_addr_y][bus.fb_addr_x];
    end

    // Observers: write log, write count, done count, distinct memory addresses
    always @(posedge clk) begin
        if (bus.fb_WE) begin
            we_count++;
            wlog.push_back(int'(bus.fb_addr_y) * 64 + int'(bus.fb_addr_x));
        end
        if (bus.done) begin
            done_count++;
        end
        if (bus.busy && (mlog.size() == 0 || mlog[$] != bus.mem_addr)) begin
            mlog.push_back(bus.mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one draw and wait for done; cyc is the done cycle counted from accept
    task automatic draw(input logic [5:0] dx, input logic [4:0] dy, input logic [3:0] dn,
                        input logic [11:0] da, output int cyc, output logic col);
        @(negedge clk);
        wlog.delete();
        mlog.delete();
        we_count   = 0;
        bus.start  = 1'b1;
        bus.x      = dx;
        bus.y      = dy;
        bus.n      = dn;
        bus.i_addr = da;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) begin
            check("done_timeout", {31'd0, bus.done}, 32'd1);
        end
        col = bus.collision;
        $display("draw x=%0d y=%0d n=%0d i=%03h: done@%0d writes=%0d collision=%0b",
                 dx, dy, dn, da, cyc, we_count, col);
    endtask

    int   cyc;
    logic col;
    int   dc0;

    initial begin
        checks     = 0;
        errors     = 0;
        we_count   = 0;
        done_count = 0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++) fb[r][c] = 1'b0;
        mem[12'h100] = 8'hF0;
        mem[12'h200] = 8'hC0;
        mem[12'h201] = 8'hC0;
        mem[12'hFFF] = 8'h80;
        mem[12'h000] = 8'h01;
        for (int a = 12'h300; a < 12'h305; a++) mem[a] = 8'hFF;

        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.x      = '0;
        bus.y      = '0;
        bus.n      = '0;
        bus.i_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_coll", {31'd0, bus.collision}, 32'd0);
        check("rst_we", {31'd0, bus.fb_WE}, 32'd0);
        check("rst_wdata", {31'd0, bus.fb_writedata}, 32'd0);
        check("rst_fbx", {26'd0, bus.fb_addr_x}, 32'd0);
        check("rst_fby", {27'd0, bus.fb_addr_y}, 32'd0);
        check("rst_maddr", {20'd0, bus.mem_addr}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0xF0 at origin on a clear buffer: 10+4+1 = 15
        draw(6'd0, 5'd0, 4'd1, 12'h100, cyc, col);
        check("t1_cycles", cyc, 15);
        check("t1_coll", {31'd0, col}, 32'd0);
        check("t1_we", we_count, 4);
        check("t1_busy_at_done", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check("t1_done_pulse", {31'd0, bus.done}, 32'd0);
        check("t1_idle", {31'd0, bus.busy}, 32'd0);
        for (int c = 0; c < 4; c++) check($sformatf("t1_px%0d", c), {31'd0, fb[0][c]}, 32'd1);
        check("t1_px4", {31'd0, fb[0][4]}, 32'd0);

        // Same draw again erases and collides
        draw(6'd0, 5'd0, 4'd1, 12'h100, cyc, col);
        check("t2_cycles", cyc, 15);
        check("t2_coll", {31'd0, col}, 32'd1);
        check("t2_we", we_count, 4);
        @(negedge clk);
        for (int c = 0; c < 4; c++) check($sformatf("t2_px%0d", c), {31'd0, fb[0][c]}, 32'd0);

        // Corner wrap: 20+4+1 = 25
        draw(6'd62, 5'd31, 4'd2, 12'h200, cyc, col);
        check("t3_cycles", cyc, 25);
        check("t3_coll", {31'd0, col}, 32'd0);
        check("t3_nwr", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check("t3_wr0", wlog[0], 31 * 64 + 62);
            check("t3_wr1", wlog[1], 31 * 64 + 63);
            check("t3_wr2", wlog[2], 0 * 64 + 62);
            check("t3_wr3", wlog[3], 0 * 64 + 63);
        end
        @(negedge clk);
        check("t3_px", {28'd0, fb[31][62], fb[31][63], fb[0][62], fb[0][63]}, 32'hF);

        // Address wrap 0xFFF -> 0x000, bytes 0x80 and 0x01: 20+2+1 = 23
        draw(6'd10, 5'd5, 4'd2, 12'hFFF, cyc, col);
        check("t4_cycles", cyc, 23);
        check("t4_naddr", mlog.size(), 2);
        if (mlog.size() == 2) begin
            check("t4_addr0", {20'd0, mlog[0]}, 32'hFFF);
            check("t4_addr1", {20'd0, mlog[1]}, 32'h000);
        end
        check("t4_nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("t4_wr0", wlog[0], 5 * 64 + 10);
            check("t4_wr1", wlog[1], 6 * 64 + 17);
        end
        // Redraw to leave collision at 1
        draw(6'd10, 5'd5, 4'd2, 12'hFFF, cyc, col);
        check("t4b_coll", {31'd0, col}, 32'd1);

        // Empty sprite
        draw(6'd3, 5'd3, 4'd0, 12'h123, cyc, col);
        check("t5_cycles", cyc, 1);
        check("t5_coll", {31'd0, col}, 32'd0);
        check("t5_we", we_count, 0);
        check("t5_maddr_hold", {20'd0, bus.mem_addr}, 32'h000);

        // Reset in the middle of the first row of a 5-row draw
        @(negedge clk);
        we_count   = 0;
        bus.start  = 1'b1;
        bus.x      = 6'd20;
        bus.y      = 5'd10;
        bus.n      = 4'd5;
        bus.i_addr = 12'h300;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        dc0 = done_count;
        check("t6_we_before", {31'd0, bus.fb_WE}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_we", {31'd0, bus.fb_WE}, 32'd0);
        check("t6_busy", {31'd0, bus.busy}, 32'd0);
        check("t6_done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        $display("reset mid-draw: writes committed=%0d", we_count);
        check("t6_writes", we_count, 1);
        check("t6_px20", {31'd0, fb[10][20]}, 32'd1);
        check("t6_px21", {31'd0, fb[10][21]}, 32'd0);
        check("t6_no_done", done_count, dc0);
        draw(6'd0, 5'd0, 4'd1, 12'h100, cyc, col);
        check("t6_restart_cycles", cyc, 15);
        check("t6_restart_coll", {31'd0, col}, 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
